// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART datapath blocks.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      FIRE       = 2'd1,
      WAIT_START = 2'd2,
      WAIT_DONE  = 2'd3
   } tx_state_t;

   localparam int unsigned DATA_W_DEF   = 8;
   localparam int unsigned DEPTH_DEF    = 16;
   localparam int unsigned START_TO_DEF = 4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy flags, overflow pulse and flush.
// Read data is the head entry, presented combinationally.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow
);

   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_nxt;
   logic              wr_ok;
   logic              rd_ok;

   // flush wins over both ports so a same-cycle write never survives a clear
   assign wr_ok   = wr_en && !full  && !flush;
   assign rd_ok   = rd_en && !empty && !flush;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (flush)
         count_nxt = '0;
      else if (wr_ok && !rd_ok)
         count_nxt = count + CNT_ONE;
      else if (!wr_ok && rd_ok)
         count_nxt = count - CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
         end
         count    <= count_nxt;
         full     <= (count_nxt == CNT_FULL);
         empty    <= (count_nxt == '0);
         overflow <= wr_en && full;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus frame scheduler feeding the UART transmitter one tx_en per byte.
//
//   state      | meaning
//   IDLE       | waiting for a byte and for the transmitter to be quiet; pops head
//   FIRE       | tx_en high for this single cycle, tx_data already loaded
//   WAIT_START | waiting up to START_TO cycles for bps_en to rise
//   WAIT_DONE  | frame in flight, waiting for bps_en to fall
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int START_TO = START_TO_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              flush,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              start_err,
   output logic              tx_en,
   output logic [DATA_W-1:0] tx_data,
   input  logic              bps_en,
   output logic              busy
);

   localparam int              TO_W    = $clog2(START_TO + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TO - 1);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

   tx_state_t         state, state_nxt;
   logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
   logic              pop;
   logic [DATA_W-1:0] head;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .rd_en    (pop),
      .rd_data  (head),
      .flush    (flush),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow)
   );

   always_comb begin
      state_nxt  = state;
      to_cnt_nxt = to_cnt;
      pop        = 1'b0;
      tx_en      = 1'b0;
      start_err  = 1'b0;
      case (state)
         IDLE: begin
            // a busy transmitter here means someone else launched it; hold off
            if (!empty && !flush && !bps_en) begin
               pop       = 1'b1;
               state_nxt = FIRE;
            end
         end
         FIRE: begin
            tx_en      = 1'b1;
            to_cnt_nxt = '0;
            state_nxt  = WAIT_START;
         end
         WAIT_START: begin
            if (bps_en) begin
               state_nxt = WAIT_DONE;
            end else if (to_cnt == TO_LAST) begin
               start_err = 1'b1;
               state_nxt = IDLE;
            end else begin
               to_cnt_nxt = to_cnt + TO_ONE;
            end
         end
         WAIT_DONE: begin
            if (!bps_en) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         to_cnt  <= '0;
         tx_data <= '0;
      end else begin
         state  <= state_nxt;
         to_cnt <= to_cnt_nxt;
         if (pop) tx_data <= head;
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder: a transmitter model drives bps_en and a
// byte queue predicts the launch order and payload of every tx_en pulse.
module tb_uart_tx_feeder;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       flush;
   logic       full, empty, overflow, start_err, tx_en, busy;
   logic [4:0] count;
   logic [7:0] tx_data;
   logic       bps_en;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q[$];
   int         tx_cnt = 0;
   int         cyc = 0;
   int         fall_cyc = 0;
   int         frame_len = 11 * 434;
   int         remaining = 0;
   bit         stall = 0, dead = 0, b2b_chk = 0, pending = 0, foreign = 0;
   logic [7:0] cur_byte = 8'h00;

   always #5 clk = ~clk;

   uart_tx_feeder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .flush     (flush),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .start_err (start_err),
      .tx_en     (tx_en),
      .tx_data   (tx_data),
      .bps_en    (bps_en),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      step();
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || busy || bps_en || !empty) && n < budget) begin
         step();
         n++;
      end
      chk({tag, "_drain_in_time"}, n < budget, 1);
   endtask

   // transmitter model: busy one cycle after tx_en for frame_len cycles
   initial begin
      bps_en = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            bps_en = 1'b0; pending = 0; foreign = 0; remaining = 0;
         end else if (stall) begin
            bps_en = 1'b1; foreign = 1;
         end else if (foreign) begin
            bps_en = 1'b0; foreign = 0;
         end else if (pending) begin
            bps_en = 1'b1; remaining = frame_len - 1; pending = 0;
         end else if (bps_en) begin
            if (remaining == 0) begin
               chk("tx_data_held_to_frame_end", tx_data, cur_byte);
               bps_en   = 1'b0;
               fall_cyc = cyc;
            end else begin
               remaining--;
            end
         end
         if (tx_en) begin
            tx_cnt++;
            chk("tx_en_while_bps", bps_en, 0);
            chk("tx_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("tx_data_order", tx_data, exp_q.pop_front());
            if (b2b_chk) chk("b2b_gap", cyc - fall_cyc, 2);
            cur_byte = tx_data;
            pending  = !dead;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, n, ovf;
      rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
      repeat (3) step();
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_start_err", start_err, 0);
      chk("rst_tx_en", tx_en, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk) rst_n = 1'b1;
      step();

      // single byte, full-length frame, launch latency
      wr(8'hA5);
      chk("lat_empty", empty, 0);
      chk("lat_count", count, 1);
      chk("lat_no_tx_yet", tx_en, 0);
      step();
      chk("lat_tx_en", tx_en, 1);
      chk("lat_tx_data", tx_data, 8'hA5);
      chk("lat_busy", busy, 1);
      step();
      chk("lat_tx_en_single", tx_en, 0);
      wait_drain(6000, "single");
      chk("single_busy_after", busy, 0);
      chk("single_tx_cnt", tx_cnt, 1);

      // burst of 16 while transmitter is held busy, then drain back-to-back
      stall = 1; step(); step();
      for (int i = 1; i <= 16; i++) wr(8'(i));
      chk("burst_full", full, 1);
      chk("burst_count", count, 16);
      chk("burst_no_launch", tx_cnt, 1);
      frame_len = $urandom_range(3, 12);
      t0 = tx_cnt;
      stall = 0;
      n = 0;
      while (tx_cnt == t0 && n < 20) begin step(); n++; end
      chk("burst_first_launch", tx_cnt > t0, 1);
      b2b_chk = 1;
      wait_drain(16 * 40 + 50, "burst");
      b2b_chk = 0;
      chk("burst_tx_cnt", tx_cnt - t0, 16);
      chk("burst_empty_end", empty, 1);

      // overflow: 17 writes into a stalled FIFO
      stall = 1; step(); step();
      ovf = 0;
      for (int i = 0; i < 17; i++) begin
         wr(8'($urandom));
         ovf += int'(overflow);
      end
      repeat (2) begin step(); ovf += int'(overflow); end
      chk("ovf_pulses", ovf, 1);
      chk("ovf_count", count, 16);
      chk("ovf_full", full, 1);
      frame_len = $urandom_range(3, 8);
      t0 = tx_cnt;
      stall = 0;
      wait_drain(16 * 40 + 50, "ovf");
      chk("ovf_tx_cnt", tx_cnt - t0, 16);

      // start timeout: transmitter never answers
      dead = 1;
      wr(8'($urandom));
      n = 0;
      while (!tx_en && n < 5) begin step(); n++; end
      chk("to_fire_seen", tx_en, 1);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("to_start_err_c%0d", k), start_err, (k == 4) ? 1 : 0);
         chk($sformatf("to_busy_c%0d", k), busy, (k <= 4) ? 1 : 0);
      end
      dead = 0;
      frame_len = $urandom_range(3, 10);
      t0 = tx_cnt;
      wr(8'($urandom));
      wait_drain(100, "to_next");
      chk("to_next_launched", tx_cnt - t0, 1);

      // flush while a frame is in flight, with a write in the same cycle
      frame_len = 60;
      for (int i = 0; i < 4; i++) wr(8'($urandom));
      n = 0;
      while (!(bps_en && busy) && n < 20) begin step(); n++; end
      chk("flush_frame_started", bps_en && busy, 1);
      step(); step();
      flush = 1'b1; wr_en = 1'b1; wr_data = 8'h3C;
      step();
      flush = 1'b0; wr_en = 1'b0;
      exp_q.delete();
      t0 = tx_cnt;
      chk("flush_count", count, 0);
      chk("flush_empty", empty, 1);
      chk("flush_frame_alive", busy, 1);
      wait_drain(200, "flush");
      repeat (10) step();
      chk("flush_no_more_tx", tx_cnt, t0);

      // asynchronous reset in the middle of a frame
      for (int i = 0; i < 3; i++) wr(8'($urandom));
      n = 0;
      while (!(bps_en && busy) && n < 20) begin step(); n++; end
      chk("rstmid_frame_started", bps_en && busy, 1);
      repeat (3) step();
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_busy", busy, 0);
      chk("rstmid_count", count, 0);
      chk("rstmid_empty", empty, 1);
      chk("rstmid_full", full, 0);
      chk("rstmid_tx_en", tx_en, 0);
      chk("rstmid_tx_data", tx_data, 0);
      exp_q.delete();
      t0 = tx_cnt;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      step();
      repeat (20) step();
      chk("rstmid_no_tx", tx_cnt, t0);
      frame_len = 8;
      wr(8'($urandom));
      wait_drain(100, "rstmid_next");
      chk("rstmid_next_launched", tx_cnt - t0, 1);

      // random traffic with random gaps and frame lengths
      for (int r = 0; r < 3; r++) begin
         frame_len = $urandom_range(3, 20);
         t0 = tx_cnt;
         for (int i = 0; i < 12; i++) begin
            wr(8'($urandom));
            repeat ($urandom_range(0, 30)) step();
         end
         wait_drain(12 * 30, $sformatf("rand%0d", r));
         chk($sformatf("rand%0d_tx_cnt", r), tx_cnt - t0, 12);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
